// File: rtl/sa1x2_sequencer.sv
// sa1x2_sequencer: operand sequencer and result collector for a 1x2 systolic
// MAC array.  Feeds a0/b0 directly and a1 through a one-cycle delay so row 1
// lines up with the array's internal b forwarding register.  It clears the
// array before each job, counts beats, drains the pipeline and holds the
// captured accumulators on a valid/ready result port.
module sa1x2_sequencer #(
    parameter int DW = 16,
    parameter int AW = 32,
    parameter int KW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [KW-1:0] len,
    output logic          busy,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_a0,
    input  logic [DW-1:0] in_a1,
    input  logic [DW-1:0] in_b,
    output logic          arr_clr,
    output logic [DW-1:0] arr_a0,
    output logic [DW-1:0] arr_a1,
    output logic [DW-1:0] arr_b0,
    input  logic [AW-1:0] arr_c0,
    input  logic [AW-1:0] arr_c1,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_c0,
    output logic [AW-1:0] out_c1
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_FLUSH = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    // Three drain cycles: one for PE0's last add, one for the b/a1 hop into
    // PE1, one for PE1's last add; the capture happens on the edge ending it.
    localparam logic [1:0] FLUSH_LAST = 2'd2;

    state_t        state_q,   state_d;
    logic [KW-1:0] len_q,     len_d;
    logic [KW-1:0] cnt_q,     cnt_d;
    logic [1:0]    flush_q,   flush_d;
    logic          arr_clr_q, arr_clr_d;
    logic [DW-1:0] arr_a0_q,  arr_a0_d;
    logic [DW-1:0] arr_a1_q,  arr_a1_d;
    logic [DW-1:0] arr_b0_q,  arr_b0_d;
    logic [DW-1:0] a1_dly_q,  a1_dly_d;
    logic [AW-1:0] out_c0_q,  out_c0_d;
    logic [AW-1:0] out_c1_q,  out_c1_d;

    logic          accept;
    logic [KW-1:0] cnt_inc;

    assign busy      = (state_q != S_IDLE);
    assign in_ready  = (state_q == S_FEED);
    assign out_valid = (state_q == S_OUT);
    assign accept    = in_valid && in_ready;
    assign cnt_inc   = cnt_q + KW'(1);

    assign arr_clr = arr_clr_q;
    assign arr_a0  = arr_a0_q;
    assign arr_a1  = arr_a1_q;
    assign arr_b0  = arr_b0_q;
    assign out_c0  = out_c0_q;
    assign out_c1  = out_c1_q;

    // Next-state and datapath: operands default to zero so every cycle that
    // is not an accepted beat presents a bubble that leaves the sums intact.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        flush_d   = flush_q;
        arr_clr_d = 1'b0;
        arr_a0_d  = '0;
        arr_a1_d  = '0;
        arr_b0_d  = '0;
        a1_dly_d  = '0;
        out_c0_d  = out_c0_q;
        out_c1_d  = out_c1_q;

        case (state_q)
            S_IDLE: begin
                if (start && (len != '0)) begin
                    len_d     = len;
                    cnt_d     = '0;
                    flush_d   = '0;
                    arr_clr_d = 1'b1;
                    state_d   = S_CLEAR;
                end
            end

            S_CLEAR: begin
                state_d = S_FEED;
            end

            S_FEED: begin
                arr_a1_d = a1_dly_q;
                if (accept) begin
                    arr_a0_d = in_a0;
                    arr_b0_d = in_b;
                    a1_dly_d = in_a1;
                    cnt_d    = cnt_inc;
                    if (cnt_inc == len_q) begin
                        flush_d = '0;
                        state_d = S_FLUSH;
                    end
                end
            end

            S_FLUSH: begin
                arr_a1_d = a1_dly_q;
                flush_d  = flush_q + 2'd1;
                if (flush_q == FLUSH_LAST) begin
                    out_c0_d = arr_c0;
                    out_c1_d = arr_c1;
                    flush_d  = '0;
                    state_d  = S_OUT;
                end
            end

            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, all returning to zero on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            flush_q   <= '0;
            arr_clr_q <= 1'b0;
            arr_a0_q  <= '0;
            arr_a1_q  <= '0;
            arr_b0_q  <= '0;
            a1_dly_q  <= '0;
            out_c0_q  <= '0;
            out_c1_q  <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            flush_q   <= flush_d;
            arr_clr_q <= arr_clr_d;
            arr_a0_q  <= arr_a0_d;
            arr_a1_q  <= arr_a1_d;
            arr_b0_q  <= arr_b0_d;
            a1_dly_q  <= a1_dly_d;
            out_c0_q  <= out_c0_d;
            out_c1_q  <= out_c1_d;
        end
    end

endmodule

// File: tb/tb_sa1x2_sequencer.sv
// tb_sa1x2_sequencer: directed bench for sa1x2_sequencer with a behavioural
// 1x2 systolic array attached to its array-side ports.
module tb_sa1x2_sequencer;

    localparam int DW = 16;
    localparam int AW = 32;
    localparam int KW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [KW-1:0] len = '0;
    logic          busy;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_a0 = '0;
    logic [DW-1:0] in_a1 = '0;
    logic [DW-1:0] in_b = '0;
    logic          arr_clr;
    logic [DW-1:0] arr_a0;
    logic [DW-1:0] arr_a1;
    logic [DW-1:0] arr_b0;
    logic [AW-1:0] arr_c0 = '0;
    logic [AW-1:0] arr_c1 = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW-1:0] out_c0;
    logic [AW-1:0] out_c1;

    logic [DW-1:0] arr_b1 = '0;

    int n_asserts = 0;
    int n_fail    = 0;

    sa1x2_sequencer #(.DW(DW), .AW(AW), .KW(KW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a0     (in_a0),
        .in_a1     (in_a1),
        .in_b      (in_b),
        .arr_clr   (arr_clr),
        .arr_a0    (arr_a0),
        .arr_a1    (arr_a1),
        .arr_b0    (arr_b0),
        .arr_c0    (arr_c0),
        .arr_c1    (arr_c1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_c0    (out_c0),
        .out_c1    (out_c1)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    // Behavioural array: PE0 multiplies a0*b0, b0 hops through one register
    // to PE1 which multiplies a1 with it; clear is the sequencer's arr_clr only.
    always @(posedge clk) begin
        if (arr_clr) begin
            arr_c0 <= '0;
            arr_c1 <= '0;
            arr_b1 <= '0;
        end else begin
            arr_c0 <= arr_c0 + AW'(arr_a0) * AW'(arr_b0);
            arr_c1 <= arr_c1 + AW'(arr_a1) * AW'(arr_b1);
            arr_b1 <= arr_b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_asserts++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Present one beat for exactly one clock edge, then drop in_valid.
    task automatic applyStimulus(input logic v, input logic [DW-1:0] a0,
                                 input logic [DW-1:0] a1, input logic [DW-1:0] b);
        in_valid = v;
        in_a0    = a0;
        in_a1    = a1;
        in_b     = b;
        step();
        in_valid = 1'b0;
        in_a0    = '0;
        in_a1    = '0;
        in_b     = '0;
    endtask

    task automatic startJob(input logic [KW-1:0] l, input string tag);
        start = 1'b1;
        len   = l;
        step();
        start = 1'b0;
        len   = '0;
        checkOutput({tag, "_clr"}, 32'(arr_clr), 32'd1);
        step();
        checkOutput({tag, "_ready"}, 32'(in_ready), 32'd1);
    endtask

    // Bounded wait for out_valid, then compare both captured results.
    task automatic waitResult(input logic [31:0] e0, input logic [31:0] e1,
                              input string tag);
        int n = 0;
        while (!out_valid && n < 12) begin
            step();
            n++;
        end
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, "_c0"}, out_c0, e0);
        checkOutput({tag, "_c1"}, out_c1, e1);
    endtask

    // Directed sequence covering reset, timing, bubbles, wrap, ignored starts,
    // output back-pressure and reset in the middle of a job.
    initial begin
        $display("[TB] start");
        rst = 1'b1;
        step();
        step();
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_arr_clr", 32'(arr_clr), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_arr_a0", 32'(arr_a0), 32'd0);
        checkOutput("rst_out_c0", out_c0, 32'd0);
        rst = 1'b0;
        step();

        // Job 1: back-to-back beats, exact latency to out_valid.
        out_ready = 1'b1;
        startJob(8'd2, "j1");
        applyStimulus(1'b1, 16'd1, 16'd2, 16'd3);
        checkOutput("j1_a0_beat1", 32'(arr_a0), 32'd1);
        checkOutput("j1_b0_beat1", 32'(arr_b0), 32'd3);
        checkOutput("j1_a1_lag", 32'(arr_a1), 32'd0);
        applyStimulus(1'b1, 16'd4, 16'd5, 16'd6);
        checkOutput("j1_a0_beat2", 32'(arr_a0), 32'd4);
        checkOutput("j1_a1_beat1", 32'(arr_a1), 32'd2);
        checkOutput("j1_flush_ready", 32'(in_ready), 32'd0);
        step();
        checkOutput("j1_a1_beat2", 32'(arr_a1), 32'd5);
        checkOutput("j1_valid_t1", 32'(out_valid), 32'd0);
        step();
        checkOutput("j1_valid_t2", 32'(out_valid), 32'd0);
        step();
        checkOutput("j1_valid_t3", 32'(out_valid), 32'd1);
        checkOutput("j1_c0", out_c0, 32'd27);
        checkOutput("j1_c1", out_c1, 32'd36);
        step();
        checkOutput("j1_valid_drop", 32'(out_valid), 32'd0);
        checkOutput("j1_idle", 32'(busy), 32'd0);

        // Job 2: bubbles between beats, plus a start pulse during FEED.
        startJob(8'd2, "j2");
        applyStimulus(1'b1, 16'd1, 16'd2, 16'd3);
        start = 1'b1;
        len   = 8'd5;
        applyStimulus(1'b0, 16'd9, 16'd9, 16'd9);
        start = 1'b0;
        len   = '0;
        checkOutput("j2_bubble1_ready", 32'(in_ready), 32'd1);
        applyStimulus(1'b0, 16'd9, 16'd9, 16'd9);
        checkOutput("j2_bubble2_ready", 32'(in_ready), 32'd1);
        applyStimulus(1'b0, 16'd9, 16'd9, 16'd9);
        checkOutput("j2_bubble3_ready", 32'(in_ready), 32'd1);
        applyStimulus(1'b1, 16'd4, 16'd5, 16'd6);
        checkOutput("j2_count_done", 32'(in_ready), 32'd0);
        waitResult(32'd27, 32'd36, "j2");
        step();

        // len==0 start is ignored.
        out_ready = 1'b0;
        start = 1'b1;
        len   = 8'd0;
        step();
        start = 1'b0;
        checkOutput("len0_busy", 32'(busy), 32'd0);
        checkOutput("len0_clr", 32'(arr_clr), 32'd0);

        // Job 3: wrap-around, then hold in OUT under back-pressure.
        startJob(8'd2, "j3");
        applyStimulus(1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        applyStimulus(1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        waitResult(32'hFFFC0002, 32'hFFFC0002, "j3");
        for (int i = 0; i < 5; i++) step();
        checkOutput("hold_valid", 32'(out_valid), 32'd1);
        checkOutput("hold_c0", out_c0, 32'hFFFC0002);
        checkOutput("hold_c1", out_c1, 32'hFFFC0002);
        out_ready = 1'b1;
        step();
        checkOutput("hold_release", 32'(out_valid), 32'd0);

        // Job 4: follow-up job proves the array was cleared.
        startJob(8'd1, "j4");
        applyStimulus(1'b1, 16'd2, 16'd3, 16'd4);
        waitResult(32'd8, 32'd12, "j4");
        step();

        // Reset in the middle of FEED, then a fresh job.
        startJob(8'd2, "j5");
        applyStimulus(1'b1, 16'd7, 16'd7, 16'd7);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("mid_rst_a0", 32'(arr_a0), 32'd0);
        checkOutput("mid_rst_b0", 32'(arr_b0), 32'd0);
        checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
        step();
        rst = 1'b0;
        step();
        startJob(8'd1, "j6");
        applyStimulus(1'b1, 16'd1, 16'd1, 16'd1);
        waitResult(32'd1, 32'd1, "j6");
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
